// File: rtl/cpu_pkg.sv
// Shared CPU definitions: CP0 register numbers, ExcCodes, handler vector,
// and the SR/Cause field positions used by the interrupt unit.
package cpu_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

  localparam int unsigned SR_IM_LO     = 10;
  localparam int unsigned SR_EXL       = 1;
  localparam int unsigned SR_IE        = 0;
  localparam int unsigned CAUSE_BD     = 31;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_EXC_LO = 2;

  typedef enum logic [0:0] {
    NORMAL  = 1'b0,
    HANDLER = 1'b1
  } cp0_state_e;

endpackage

// File: rtl/cp0_int_arbiter.sv
// Combinational interrupt/exception arbitration: decides take and computes
// the ExcCode and EPC that the register file latches on a take.
module cp0_int_arbiter
  import cpu_pkg::*;
(
  input  logic [5:0]  ip,
  input  logic [5:0]  im,
  input  logic        ie,
  input  logic        exl,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic        bd_m,
  input  logic [31:0] pc_m,
  output logic        take,
  output logic [4:0]  exc_code_nxt,
  output logic [31:0] epc_nxt
);

  logic int_pend;

  always_comb begin
    int_pend     = (|(ip & im)) & ie & ~exl;
    take         = int_pend | (exc_req & ~exl);
    exc_code_nxt = int_pend ? EXC_INT : exc_code;
    // Delay-slot victims restart at the branch so the branch re-executes.
    epc_nxt      = (bd_m ? pc_m - 32'd4 : pc_m) & ~32'd3;
  end

endmodule

// File: rtl/cp0_int_unit.sv
// CP0 interrupt/exception receiver: holds SR, Cause, EPC, PRId, samples
// HWInt every cycle, and flushes/redirects the pipeline on take.
module cp0_int_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] PRID       = 32'h0000_0000,
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hwint,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic        exc_req,
  input  logic [4:0]  exc_code,
  input  logic        eret_m,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        take,
  output logic [31:0] epc_out
);

  cp0_state_e  state;
  logic [5:0]  im;
  logic        ie;
  logic [5:0]  ip;
  logic        bd;
  logic [4:0]  exccode;
  logic [31:0] epc;

  logic        exl;
  logic        arb_take;
  logic [4:0]  exc_code_nxt;
  logic [31:0] epc_nxt;

  assign exl = (state == HANDLER);

  cp0_int_arbiter u_arb (
    .ip           (ip),
    .im           (im),
    .ie           (ie),
    .exl          (exl),
    .exc_req      (exc_req),
    .exc_code     (exc_code),
    .bd_m         (bd_m),
    .pc_m         (pc_m),
    .take         (arb_take),
    .exc_code_nxt (exc_code_nxt),
    .epc_nxt      (epc_nxt)
  );

  // Gated so a raw exc_req cannot leak a redirect while reset is held.
  assign take    = arb_take & reset;
  assign epc_out = epc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= NORMAL;
      im      <= '0;
      ie      <= 1'b0;
      ip      <= '0;
      bd      <= 1'b0;
      exccode <= '0;
      epc     <= '0;
    end else begin
      ip <= hwint;
      if (arb_take) begin
        state   <= HANDLER;
        exccode <= exc_code_nxt;
        bd      <= bd_m;
        epc     <= epc_nxt;
      end else begin
        if (eret_m) state <= NORMAL;
        if (we && addr == CP0_SR) begin
          im    <= wdata[SR_IM_LO +: 6];
          ie    <= wdata[SR_IE];
          state <= wdata[SR_EXL] ? HANDLER : NORMAL;
        end
        if (we && addr == CP0_EPC) epc <= {wdata[31:2], 2'b00};
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      CP0_SR: begin
        rdata[SR_IM_LO +: 6] = im;
        rdata[SR_EXL]        = exl;
        rdata[SR_IE]         = ie;
      end
      CP0_CAUSE: begin
        rdata[CAUSE_BD]            = bd;
        rdata[CAUSE_IP_LO +: 6]    = ip;
        rdata[CAUSE_EXC_LO +: 5]   = exccode;
      end
      CP0_EPC:  rdata = epc;
      CP0_PRID: rdata = PRID;
      default:  rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_int_unit.sv
// Directed-vector bench for cp0_int_unit with hand-computed expectations.
module tb_cp0_int_unit;

  localparam logic [31:0] TB_PRID = 32'h0001_8000;

  logic        clk;
  logic        reset;
  logic [5:0]  hwint;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic        eret_m;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        take;
  logic [31:0] epc_out;

  int vectors = 0;
  int errors  = 0;
  logic [31:0] v;

  cp0_int_unit #(.PRID(TB_PRID), .HANDLER_PC(32'h0000_4180)) dut (
    .clk      (clk),
    .reset    (reset),
    .hwint    (hwint),
    .pc_m     (pc_m),
    .bd_m     (bd_m),
    .exc_req  (exc_req),
    .exc_code (exc_code),
    .eret_m   (eret_m),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .take     (take),
    .epc_out  (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] val);
    addr = a;
    #1;
    val = rdata;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0; wdata = '0;
  endtask

  // Drops hwint, lets IP clear, then erets back to NORMAL.
  task automatic leave_handler();
    hwint = '0; bd_m = 1'b0; exc_req = 1'b0;
    tick();
    eret_m = 1'b1;
    tick();
    eret_m = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    vectors++; if (take !== 1'b0) begin errors++; $display("FAIL reset_take got %0b want 0", take); end
    rd(5'd12, v);
    vectors++; if (v !== 32'h0) begin errors++; $display("FAIL reset_sr got %h want 00000000", v); end
    rd(5'd13, v);
    vectors++; if (v !== 32'h0) begin errors++; $display("FAIL reset_cause got %h want 00000000", v); end
    rd(5'd14, v);
    vectors++; if (v !== 32'h0) begin errors++; $display("FAIL reset_epc got %h want 00000000", v); end
    rd(5'd3, v);
    vectors++; if (v !== 32'h0) begin errors++; $display("FAIL reset_other got %h want 00000000", v); end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_interrupt();
    mtc0(5'd12, 32'h0000_0401);
    rd(5'd12, v);
    vectors++; if (v !== 32'h0000_0401) begin errors++; $display("FAIL int_sr_write got %h want 00000401", v); end
    pc_m = 32'h0000_3014; hwint = 6'b000001;
    #1;
    vectors++; if (take !== 1'b0) begin errors++; $display("FAIL int_take_before_sample got %0b want 0", take); end
    tick();
    vectors++; if (take !== 1'b1) begin errors++; $display("FAIL int_take got %0b want 1", take); end
    tick();
    vectors++; if (take !== 1'b0) begin errors++; $display("FAIL int_take_masked got %0b want 0", take); end
    rd(5'd14, v);
    vectors++; if (v !== 32'h0000_3014) begin errors++; $display("FAIL int_epc got %h want 00003014", v); end
    rd(5'd13, v);
    vectors++; if (v !== 32'h0000_0400) begin errors++; $display("FAIL int_cause got %h want 00000400", v); end
    rd(5'd12, v);
    vectors++; if (v !== 32'h0000_0403) begin errors++; $display("FAIL int_sr_exl got %h want 00000403", v); end
    pc_m = 32'h0000_41d0;
    tick(); tick();
    vectors++; if (take !== 1'b0) begin errors++; $display("FAIL handler_nested got %0b want 0", take); end
    eret_m = 1'b1;
    #1;
    vectors++; if (epc_out !== 32'h0000_3014) begin errors++; $display("FAIL eret_epc_out got %h want 00003014", epc_out); end
    vectors++; if (take !== 1'b0) begin errors++; $display("FAIL eret_take got %0b want 0", take); end
    tick();
    eret_m = 1'b0; pc_m = 32'h0000_3014;
    #1;
    vectors++; if (take !== 1'b1) begin errors++; $display("FAIL eret_retake got %0b want 1", take); end
    rd(5'd12, v);
    vectors++; if (v !== 32'h0000_0401) begin errors++; $display("FAIL eret_sr got %h want 00000401", v); end
    tick();
    vectors++; if (epc_out !== 32'h0000_3014) begin errors++; $display("FAIL retake_epc got %h want 00003014", epc_out); end
    leave_handler();
  endtask

  task automatic test_bd();
    pc_m = 32'h0000_3018; bd_m = 1'b1; hwint = 6'b000001;
    tick();
    vectors++; if (take !== 1'b1) begin errors++; $display("FAIL bd_take got %0b want 1", take); end
    tick();
    rd(5'd14, v);
    vectors++; if (v !== 32'h0000_3014) begin errors++; $display("FAIL bd_epc got %h want 00003014", v); end
    rd(5'd13, v);
    vectors++; if (v !== 32'h8000_0400) begin errors++; $display("FAIL bd_cause got %h want 80000400", v); end
    leave_handler();
  endtask

  task automatic test_ie_write();
    mtc0(5'd12, 32'h0000_0400);
    hwint = 6'b000001;
    tick(); tick();
    vectors++; if (take !== 1'b0) begin errors++; $display("FAIL iewr_disabled got %0b want 0", take); end
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0401; pc_m = 32'h0000_3040;
    #1;
    vectors++; if (take !== 1'b0) begin errors++; $display("FAIL iewr_write_cycle got %0b want 0", take); end
    tick();
    we = 1'b0; wdata = '0;
    #1;
    vectors++; if (take !== 1'b1) begin errors++; $display("FAIL iewr_after got %0b want 1", take); end
    tick();
    leave_handler();
  endtask

  task automatic test_priority();
    hwint = 6'b000001;
    tick();
    exc_req = 1'b1; exc_code = 5'd12; pc_m = 32'h0000_3020;
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_0000;
    #1;
    vectors++; if (take !== 1'b1) begin errors++; $display("FAIL prio_take got %0b want 1", take); end
    tick();
    exc_req = 1'b0; we = 1'b0;
    rd(5'd13, v);
    vectors++; if (v !== 32'h0000_0400) begin errors++; $display("FAIL prio_cause got %h want 00000400", v); end
    rd(5'd12, v);
    vectors++; if (v !== 32'h0000_0403) begin errors++; $display("FAIL prio_sr_discard got %h want 00000403", v); end
    rd(5'd14, v);
    vectors++; if (v !== 32'h0000_3020) begin errors++; $display("FAIL prio_epc got %h want 00003020", v); end
    leave_handler();
  endtask

  task automatic test_exception();
    mtc0(5'd12, 32'h0000_0000);
    pc_m = 32'h0000_3000; exc_req = 1'b1; exc_code = 5'd10;
    #1;
    vectors++; if (take !== 1'b1) begin errors++; $display("FAIL exc_take got %0b want 1", take); end
    tick();
    exc_req = 1'b0;
    rd(5'd13, v);
    vectors++; if (v !== 32'h0000_0028) begin errors++; $display("FAIL exc_cause got %h want 00000028", v); end
    rd(5'd14, v);
    vectors++; if (v !== 32'h0000_3000) begin errors++; $display("FAIL exc_epc got %h want 00003000", v); end
    rd(5'd12, v);
    vectors++; if (v !== 32'h0000_0002) begin errors++; $display("FAIL exc_sr got %h want 00000002", v); end
    exc_req = 1'b1; exc_code = 5'd4; pc_m = 32'h0000_3004;
    #1;
    vectors++; if (take !== 1'b0) begin errors++; $display("FAIL exc_nested got %0b want 0", take); end
    tick();
    exc_req = 1'b0;
    rd(5'd13, v);
    vectors++; if (v !== 32'h0000_0028) begin errors++; $display("FAIL exc_nested_cause got %h want 00000028", v); end
    mtc0(5'd14, 32'h0000_1235);
    rd(5'd14, v);
    vectors++; if (v !== 32'h0000_1234) begin errors++; $display("FAIL epc_align got %h want 00001234", v); end
    mtc0(5'd13, 32'hffff_ffff);
    rd(5'd13, v);
    vectors++; if (v !== 32'h0000_0028) begin errors++; $display("FAIL cause_ro got %h want 00000028", v); end
  endtask

  task automatic test_async_reset();
    rd(5'd12, v);
    vectors++; if (v !== 32'h0000_0002) begin errors++; $display("FAIL ar_pre_exl got %h want 00000002", v); end
    exc_req = 1'b1; exc_code = 5'd5;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    vectors++; if (take !== 1'b0) begin errors++; $display("FAIL ar_take got %0b want 0", take); end
    vectors++; if (epc_out !== 32'h0) begin errors++; $display("FAIL ar_epc_out got %h want 00000000", epc_out); end
    rd(5'd12, v);
    vectors++; if (v !== 32'h0) begin errors++; $display("FAIL ar_sr got %h want 00000000", v); end
    rd(5'd13, v);
    vectors++; if (v !== 32'h0) begin errors++; $display("FAIL ar_cause got %h want 00000000", v); end
    rd(5'd15, v);
    vectors++; if (v !== TB_PRID) begin errors++; $display("FAIL ar_prid got %h want %h", v, TB_PRID); end
    exc_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  initial begin
    hwint = '0; pc_m = '0; bd_m = 1'b0; exc_req = 1'b0; exc_code = '0;
    eret_m = 1'b0; we = 1'b0; addr = '0; wdata = '0; reset = 1'b0;
    test_reset();
    test_interrupt();
    test_bd();
    test_ie_write();
    test_priority();
    test_exception();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
